// File: rtl/fwb_pkg.sv
// Shared constants for the Wishbone B4 pipelined slave-port monitor.
// Fault bit positions, the "limit disabled" value and the request-limit helper.
package fwb_pkg;

    localparam int FAULT_MASTER = 0;
    localparam int FAULT_SLAVE  = 1;
    localparam int LIMIT_OFF    = 0;
    localparam int RUN_W        = 16;

    // A zero request limit means "as deep as the counters allow, less headroom".
    function automatic int max_reqs(input int lgdepth, input int req);
        return (req == LIMIT_OFF) ? (1 << lgdepth) - 2 : req;
    endfunction

endpackage

// File: rtl/fwb_req_tracker.sv
// Request/response counters for one Wishbone bus cycle.
// Ports: clk, reset, cyc, accept, response in; nreqs, nacks, outstanding out.
module fwb_req_tracker #(
    parameter int LGDEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cyc,
    input  logic               accept,
    input  logic               response,
    output logic [LGDEPTH-1:0] nreqs,
    output logic [LGDEPTH-1:0] nacks,
    output logic [LGDEPTH-1:0] outstanding
);

    always_ff @(posedge clk) begin
        if (reset || !cyc) begin
            nreqs <= '0;
            nacks <= '0;
        end else begin
            nreqs <= nreqs + LGDEPTH'(accept);
            nacks <= nacks + LGDEPTH'(response);
        end
    end

    assign outstanding = cyc ? (nreqs - nacks) : '0;

endmodule

// File: rtl/fwb_slave_monitor.sv
// Passive Wishbone B4 pipelined protocol monitor bound at a slave port.
// Counts requests/acks and raises sticky faults: f_fault[0] master rule,
// f_fault[1] slave rule. Inputs: i_clk, i_reset, all i_wb_* bus signals.
// Outputs: f_nreqs, f_nacks, f_outstanding, f_fault.
// Define FWB_FORMAL_EN to also emit the rules as SVA assume/assert.
module fwb_slave_monitor
    import fwb_pkg::*;
#(
    parameter int AW                   = 32,
    parameter int DW                   = 32,
    parameter int F_LGDEPTH            = 4,
    parameter int F_MAX_REQUESTS       = 0,
    parameter int F_MAX_STALL          = 0,
    parameter int F_MAX_ACK_DELAY      = 0,
    parameter int F_OPT_RMW_BUS_OPTION = 1,
    parameter int F_OPT_DISCONTINUOUS  = 0,
    parameter int F_OPT_MINCLOCK_DELAY = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_we,
    input  logic [AW-1:0]        i_wb_addr,
    input  logic [DW-1:0]        i_wb_data,
    input  logic [DW/8-1:0]      i_wb_sel,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_stall,
    input  logic [DW-1:0]        i_wb_idata,
    input  logic                 i_wb_err,
    output logic [F_LGDEPTH-1:0] f_nreqs,
    output logic [F_LGDEPTH-1:0] f_nacks,
    output logic [F_LGDEPTH-1:0] f_outstanding,
    output logic [1:0]           f_fault
);

    localparam logic [31:0]    MAX_REQ   = 32'(max_reqs(F_LGDEPTH, F_MAX_REQUESTS));
    localparam logic [RUN_W:0] STALL_LIM = (RUN_W+1)'(F_MAX_STALL);
    localparam logic [RUN_W:0] DELAY_LIM = (RUN_W+1)'(F_MAX_ACK_DELAY);

    logic accept;
    logic response;

    assign accept   = i_wb_cyc & i_wb_stb & ~i_wb_stall;
    assign response = i_wb_cyc & (i_wb_ack | i_wb_err);

    fwb_req_tracker #(
        .LGDEPTH(F_LGDEPTH)
    ) u_tracker (
        .clk        (i_clk),
        .reset      (i_reset),
        .cyc        (i_wb_cyc),
        .accept     (accept),
        .response   (response),
        .nreqs      (f_nreqs),
        .nacks      (f_nacks),
        .outstanding(f_outstanding)
    );

    // Previous-clock view of the bus.
    logic            past_valid;
    logic            past_reset;
    logic            past_cyc;
    logic            past_hold;
    logic            past_err;
    logic            past_we;
    logic [AW-1:0]   past_addr;
    logic [DW-1:0]   past_data;
    logic [DW/8-1:0] past_sel;

    always_ff @(posedge i_clk) begin
        past_valid <= 1'b1;
        past_reset <= i_reset;
        past_we    <= i_wb_we;
        past_addr  <= i_wb_addr;
        past_data  <= i_wb_data;
        past_sel   <= i_wb_sel;
        if (i_reset) begin
            past_cyc  <= 1'b0;
            past_hold <= 1'b0;
            past_err  <= 1'b0;
        end else begin
            past_cyc  <= i_wb_cyc;
            past_hold <= i_wb_cyc & i_wb_stb & i_wb_stall;
            past_err  <= i_wb_cyc & i_wb_err;
        end
    end

    // Per-cycle history: strobe seen / strobe dropped, first request direction.
    logic stb_seen;
    logic stb_gone;
    logic req_seen;
    logic req_we;

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_wb_cyc) begin
            stb_seen <= 1'b0;
            stb_gone <= 1'b0;
            req_seen <= 1'b0;
            req_we   <= 1'b0;
        end else begin
            stb_seen <= stb_seen | i_wb_stb;
            stb_gone <= stb_gone | (stb_seen & ~i_wb_stb);
            if (i_wb_stb && !req_seen) begin
                req_seen <= 1'b1;
                req_we   <= i_wb_we;
            end
        end
    end

    // Run lengths of stalled strobes and of unanswered outstanding requests,
    // counting the current clock, saturating.
    logic             stalled;
    logic             waiting;
    logic [RUN_W-1:0] stall_run;
    logic [RUN_W-1:0] ack_wait;
    logic [RUN_W:0]   stall_next;
    logic [RUN_W:0]   wait_next;

    assign stalled    = i_wb_cyc & i_wb_stb & i_wb_stall;
    assign waiting    = (f_outstanding != '0) & ~response;
    assign stall_next = {1'b0, stall_run} + 1'b1;
    assign wait_next  = {1'b0, ack_wait} + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset || !stalled)
            stall_run <= '0;
        else if (stall_run != '1)
            stall_run <= stall_run + 1'b1;
        if (i_reset || !waiting)
            ack_wait <= '0;
        else if (ack_wait != '1)
            ack_wait <= ack_wait + 1'b1;
    end

    // Master-side rules.
    logic m_reset_cyc;
    logic m_stb_nocyc;
    logic m_hold;
    logic m_err_cyc;
    logic m_overflow;
    logic m_we_change;
    logic m_restart;
    logic m_bad;

    assign m_reset_cyc = past_valid & past_reset & i_wb_cyc;
    assign m_stb_nocyc = i_wb_stb & ~i_wb_cyc;
    // A stalled request must be re-presented unchanged unless the cycle aborts.
    assign m_hold      = past_hold & i_wb_cyc
                       & (~i_wb_stb
                          | (i_wb_addr != past_addr)
                          | (i_wb_we != past_we)
                          | (i_wb_sel != past_sel)
                          | (i_wb_we & (i_wb_data != past_data)));
    assign m_err_cyc   = past_err & i_wb_cyc;
    assign m_overflow  = 32'(f_nreqs) > MAX_REQ;
    assign m_we_change = (F_OPT_RMW_BUS_OPTION == 0)
                       & i_wb_cyc & i_wb_stb & req_seen & (i_wb_we != req_we);
    assign m_restart   = (F_OPT_DISCONTINUOUS == 0)
                       & i_wb_cyc & i_wb_stb & stb_gone;
    assign m_bad       = m_reset_cyc | m_stb_nocyc | m_hold | m_err_cyc
                       | m_overflow | m_we_change | m_restart;

    // Slave-side rules.
    logic s_abort;
    logic s_both;
    logic s_count;
    logic s_unsol;
    logic s_stall;
    logic s_delay;
    logic s_bad;

    assign s_abort = past_valid & ~past_cyc & ~i_wb_cyc & (i_wb_ack | i_wb_err);
    assign s_both  = i_wb_ack & i_wb_err;
    assign s_count = f_nacks > f_nreqs;
    // Same-clock accept only counts as a pending request when allowed.
    assign s_unsol = response & (f_outstanding == '0)
                   & ~((F_OPT_MINCLOCK_DELAY == 0) & accept);
    assign s_stall = (F_MAX_STALL != LIMIT_OFF) & stalled
                   & (stall_next >= STALL_LIM);
    assign s_delay = (F_MAX_ACK_DELAY != LIMIT_OFF) & waiting
                   & (wait_next >= DELAY_LIM);
    assign s_bad   = s_abort | s_both | s_count | s_unsol | s_stall | s_delay;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            f_fault <= 2'b00;
        end else begin
            f_fault[FAULT_MASTER] <= f_fault[FAULT_MASTER] | m_bad;
            f_fault[FAULT_SLAVE]  <= f_fault[FAULT_SLAVE] | s_bad;
        end
    end

    // Read data is deliberately not checked.
    logic unused_idata;
    assign unused_idata = ^i_wb_idata;

`ifdef FWB_FORMAL_EN
    always @(posedge i_clk) begin
        if (past_valid && !i_reset) begin
            if ($past(i_reset))
                assume (!i_wb_cyc);
            assume (!m_stb_nocyc);
            if (!$past(i_reset) && $past(stalled) && i_wb_cyc) begin
                assume (i_wb_stb);
                assume (i_wb_addr == $past(i_wb_addr));
                assume (i_wb_we == $past(i_wb_we));
                assume (i_wb_sel == $past(i_wb_sel));
                if (i_wb_we)
                    assume (i_wb_data == $past(i_wb_data));
            end
            if (!$past(i_reset) && $past(i_wb_cyc && i_wb_err))
                assume (!i_wb_cyc);
            assume (!m_overflow);
            assume (!m_we_change);
            assume (!m_restart);
            if (!$past(i_wb_cyc) && !i_wb_cyc)
                assert (!i_wb_ack && !i_wb_err);
            assert (!s_both);
            assert (!s_unsol);
            assert (!s_stall);
            assert (!s_delay);
            assert (f_nacks <= f_nreqs);
            assert (f_outstanding == (i_wb_cyc ? f_nreqs - f_nacks : '0));
        end
    end
`endif

endmodule

// File: tb/tb_fwb_slave_monitor.sv
// Directed self-checking bench for fwb_slave_monitor.
// Three instances share the bus: default, ack-delay limit 2, min-clock delay.
module tb_fwb_slave_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we, ack, stall, err;
    logic [31:0] addr, data, idata;
    logic [3:0]  sel;

    logic [3:0] d_nreqs, d_nacks, d_out;
    logic [1:0] d_fault;
    logic [3:0] a_nreqs, a_nacks, a_out;
    logic [1:0] a_fault;
    logic [3:0] m_nreqs, m_nacks, m_out;
    logic [1:0] m_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwb_slave_monitor dut (
        .i_clk(clk), .i_reset(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel),
        .i_wb_ack(ack), .i_wb_stall(stall), .i_wb_idata(idata),
        .i_wb_err(err),
        .f_nreqs(d_nreqs), .f_nacks(d_nacks),
        .f_outstanding(d_out), .f_fault(d_fault)
    );

    fwb_slave_monitor #(.F_MAX_ACK_DELAY(2)) dut_ad (
        .i_clk(clk), .i_reset(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel),
        .i_wb_ack(ack), .i_wb_stall(stall), .i_wb_idata(idata),
        .i_wb_err(err),
        .f_nreqs(a_nreqs), .f_nacks(a_nacks),
        .f_outstanding(a_out), .f_fault(a_fault)
    );

    fwb_slave_monitor #(.F_OPT_MINCLOCK_DELAY(1)) dut_mc (
        .i_clk(clk), .i_reset(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel),
        .i_wb_ack(ack), .i_wb_stall(stall), .i_wb_idata(idata),
        .i_wb_err(err),
        .f_nreqs(m_nreqs), .f_nacks(m_nacks),
        .f_outstanding(m_out), .f_fault(m_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        cyc = 0; stb = 0; we = 0; ack = 0; stall = 0; err = 0;
        addr = 0; data = 0; sel = 4'hf; idata = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
        tick();
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        tick();
        chk("rst_nreqs", 32'(d_nreqs), 32'd0);
        chk("rst_nacks", 32'(d_nacks), 32'd0);
        chk("rst_out", 32'(d_out), 32'd0);
        chk("rst_fault", 32'(d_fault), 32'd0);
        rst = 0;
        tick();

        // Single read, ack one clock later.
        cyc = 1; stb = 1; addr = 32'h100;
        tick();
        chk("rd_nreqs", 32'(d_nreqs), 32'd1);
        chk("rd_out1", 32'(d_out), 32'd1);
        stb = 0; ack = 1;
        tick();
        chk("rd_nacks", 32'(d_nacks), 32'd1);
        chk("rd_out0", 32'(d_out), 32'd0);
        chk("rd_fault", 32'(d_fault), 32'd0);
        ack = 0; cyc = 0;
        tick();
        chk("rd_clr", 32'(d_nreqs), 32'd0);

        // Three pipelined writes, each acked one clock later.
        cyc = 1; stb = 1; we = 1; addr = 32'h20; data = 32'hA0;
        tick();
        addr = 32'h24; data = 32'hA4; ack = 1;
        tick();
        addr = 32'h28; data = 32'hA8;
        tick();
        stb = 0;
        tick();
        chk("wr_nreqs", 32'(d_nreqs), 32'd3);
        chk("wr_nacks", 32'(d_nacks), 32'd3);
        chk("wr_fault", 32'(d_fault), 32'd0);
        ack = 0; cyc = 0; we = 0;
        tick();
        chk("wr_clr_r", 32'(d_nreqs), 32'd0);
        chk("wr_clr_a", 32'(d_nacks), 32'd0);

        // Stalled request changes address.
        do_reset();
        cyc = 1; stb = 1; stall = 1; addr = 32'h10;
        tick();
        chk("hold_ok", 32'(d_fault), 32'd0);
        addr = 32'h14;
        tick();
        chk("hold_bad", 32'(d_fault), 32'b01);
        // Reset while the cycle is still open.
        rst = 1;
        tick();
        chk("midrst_f", 32'(d_fault), 32'd0);
        chk("midrst_n", 32'(d_nreqs), 32'd0);
        idle();
        tick();
        rst = 0;
        tick();

        // Unsolicited ack.
        cyc = 1;
        tick();
        chk("unsol_pre", 32'(d_fault), 32'd0);
        ack = 1;
        tick();
        chk("unsol", 32'(d_fault), 32'b10);

        // ack and err together, master drops cyc properly.
        do_reset();
        cyc = 1; stb = 1;
        tick();
        stb = 0; ack = 1; err = 1;
        tick();
        idle();
        tick();
        chk("ackerr", 32'(d_fault), 32'b10);

        // err with cyc held afterwards.
        do_reset();
        cyc = 1; stb = 1;
        tick();
        stb = 0; err = 1;
        tick();
        err = 0;
        tick();
        chk("err_cyc", 32'(d_fault), 32'b01);

        // Strobe without cycle.
        do_reset();
        stb = 1;
        tick();
        chk("stb_nocyc", 32'(d_fault), 32'b01);

        // Strobe restart inside one cycle.
        do_reset();
        cyc = 1; stb = 1;
        tick();
        stb = 0;
        tick();
        chk("restart_pre", 32'(d_fault), 32'd0);
        stb = 1;
        tick();
        chk("restart", 32'(d_fault), 32'b01);

        // Request count limit (14 with 4-bit counters).
        do_reset();
        cyc = 1; stb = 1;
        for (int i = 0; i < 15; i++) tick();
        chk("ovf_n", 32'(d_nreqs), 32'd15);
        chk("ovf_out", 32'(d_out), 32'd15);
        chk("ovf_pre", 32'(d_fault), 32'd0);
        stb = 0;
        tick();
        chk("ovf", 32'(d_fault), 32'b01);

        // Ack delay limit 2: no ack for two clocks.
        do_reset();
        cyc = 1; stb = 1;
        tick();
        stb = 0;
        tick();
        chk("dly_pre", 32'(a_fault), 32'd0);
        tick();
        chk("dly", 32'(a_fault), 32'b10);
        chk("dly_def", 32'(d_fault), 32'd0);

        // Ack delay limit 2: ack the clock after the request.
        do_reset();
        cyc = 1; stb = 1;
        tick();
        stb = 0; ack = 1;
        tick();
        ack = 0;
        tick();
        tick();
        chk("dly_ok", 32'(a_fault), 32'd0);
        cyc = 0;
        tick();

        // Ack in the same clock as its accept.
        do_reset();
        cyc = 1;
        tick();
        stb = 1; ack = 1;
        tick();
        chk("mc_fault", 32'(m_fault), 32'b10);
        chk("mc_def", 32'(d_fault), 32'd0);
        chk("mc_nreqs", 32'(d_nreqs), 32'd1);
        chk("mc_nacks", 32'(d_nacks), 32'd1);
        idle();
        tick();
        chk("mc_after", 32'(d_fault), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
